alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU with a start/done handshake and an iterative multiplier. It is the next generation of the lab ALU: W-bit operands, a 4-bit opcode, and a persistent CO/OVF/N/Z flag register so that ADC/SBC chain across operations. It sits between the operand source (register file or test sequencer) and the result write-back, and is exercised by a vector-driven bench.

## Interface
- W, 8, operand/result width; power of two, 4..32. LOG2W = clog2(W) is derived internally.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- SrcA  in  W  operand A
- SrcB  in  W  operand B (shift amount for shift ops)
- Control  in  4  opcode, sampled with start
- busy  out  1  multiply in progress; start is ignored while high
- done  out  1  one-cycle pulse; Result and flags are valid from that cycle
- Result  out  W  registered result, held until the next completion
- CO, OVF, N, Z  out  1 each  registered flag register

## Operation
- Opcodes:
  - 0000 ADD A+B; 0001 SUB A-B; 0010 RSB B-A
  - 0011 ADC A+B+CO; 0100 SBC A-B-1+CO
  - 0101 AND; 0110 ORR; 0111 XOR; 1000 BIC A&~B; 1001 MOV B; 1010 MVN ~B
  - 1011 MUL, low W bits of A*B, multi-cycle
  - 1100 LSL; 1101 LSR; 1110 ASR; 1111 ROR (A shifted by SrcB)
- Arithmetic uses a W+1-bit sum.
  - SUB/RSB/SBC are computed as X + ~Y + cin.
  - CO = bit W of that sum; for subtraction CO=1 means no borrow.
  - OVF = signed overflow: operands of equal sign whose result has the other sign.
- Logic and MOV/MVN leave CO and OVF unchanged.
- MUL:
  - CO is unchanged.
  - OVF=1 iff the upper W bits of the 2W-bit unsigned product are nonzero.
- Shifts:
  - Amount 0: Result=A; CO and OVF unchanged.
  - LSL/LSR, amount 1..W-1: CO = last bit shifted out.
  - LSL/LSR, amount >=W: Result=0, CO=0.
  - ASR, amount >=W: Result is all copies of A[W-1], CO=A[W-1].
  - ROR uses amount = SrcB[LOG2W-1:0]. If that amount is nonzero, CO=Result[W-1].
  - OVF is always unchanged by shifts.
- N = Result[W-1] and Z = (Result==0) are updated by every completed op.
- States:
  - IDLE: start=1 with a non-MUL op goes to IDLE and completes on that edge. start=1 with MUL goes to MUL.
  - MUL: shift-add, one partial product per cycle, W iterations, internal 2W-bit accumulator. Returns to IDLE on the final iteration and completes there.
- Operands and opcode are latched at acceptance. SrcA, SrcB and Control may change freely during busy.
- start while busy=1 is dropped; it is not queued.

## Timing
- Reset (asynchronous assert, any state) forces:
  - FSM to IDLE, busy=0, done=0
  - Result=0, CO=0, OVF=0, N=0, Z=0
  - Multiplier accumulator and counter cleared
  - A MUL in flight is abandoned with no done.
- Single-cycle op with start sampled at edge t:
  - Result, flags and done=1 register at edge t, so they are visible in cycle t..t+1.
  - done returns to 0 at edge t+1 unless a new op completes there.
- Back-to-back single-cycle ops: start held high gives one completion and one done pulse per cycle.
- MUL accepted at edge t:
  - busy=1 from edge t.
  - Iterations occur at edges t+1..t+W.
  - At edge t+W: Result and flags update, done=1, busy=0.
  - A start in the cycle after edge t+W is accepted normally.
- ADC/SBC use the CO value held at the accepting edge, including a CO produced on the immediately preceding edge.
- Result and flags never change except at a completion or a reset.

## Test plan (W=8)
- Signed overflow and zero:
  - ADD 0x7F,0x01 -> Result 0x80, CO=0 OVF=1 N=1 Z=0, done for 1 cycle.
  - Then SUB 0x05,0x05 -> 0x00, CO=1 OVF=0 N=0 Z=1.
- Carry chain:
  - ADD 0xFF,0x01 -> 0x00, CO=1.
  - Next cycle ADC 0x10,0x20 -> 0x31, CO=0.
  - SBC 0x10,0x01 with CO=0 -> 0x0E.
- Multiply:
  - MUL 0x0F,0x11 -> 0xFF, OVF=0, CO unchanged. busy for exactly 8 cycles; done at edge t+8.
  - MUL 0x10,0x10 -> 0x00, OVF=1, Z=1.
- Busy and reset:
  - start with AND 0xF0,0x3C during MUL busy -> ignored; only the MUL done appears.
  - reset_n low at iteration 4 of a MUL -> all outputs 0 immediately, no done. Next ADD 0x01,0x02 -> 0x03.
- Shifts:
  - LSR 0x81 by 1 -> 0x40, CO=1.
  - ASR 0x80 by 3 -> 0xF0, CO=0.
  - LSL 0x81 by 9 -> 0x00, CO=0, Z=1.
  - ROR 0x01 by 1 -> 0x80, CO=1, N=1.
  - LSL by 0 -> A, flags CO/OVF unchanged.
- Logic ops preserve CO/OVF:
  - After ADD 0xFF,0x01 (CO=1), BIC 0xFF,0x0F -> 0xF0, CO=1, N=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered W-bit ALU with persistent CO/OVF/N/Z flags and an iterative shift-add multiplier.
// Single-cycle ops complete at the accepting edge; MUL completes W edges later. start is dropped while busy.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] SrcA,
  input  logic [W-1:0] SrcB,
  input  logic [3:0]   Control,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Result,
  output logic         CO,
  output logic         OVF,
  output logic         N,
  output logic         Z
);

  localparam int LOG2W = $clog2(W);
  localparam logic [W:0] WIDTH_V = (W+1)'(W);
  localparam logic [LOG2W-1:0] CNT_LAST = LOG2W'(W-1);
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic {IDLE, MULT} state_t;

  state_t state, state_nxt;
  logic   accept, last;

  logic [2*W-1:0] acc, mcand, acc_nxt;
  logic [W-1:0]   mplier;
  logic [LOG2W-1:0] cnt;

  logic [W-1:0] res, ax, ay;
  logic         co_n, ovf_n, cin, arith;
  logic [W:0]   sum, shl, shr, sar;
  logic [W-1:0] rot;
  logic [LOG2W-1:0] ramt;
  logic         big, zamt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept = 1'b1;
        if (Control == OP_MUL) state_nxt = MULT;
      end
      MULT: if (cnt == CNT_LAST) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == MULT);

  // Shifters keep one extra bit so the last bit shifted out falls out as the carry.
  assign ramt = SrcB[LOG2W-1:0];
  assign shl  = {1'b0, SrcA} << SrcB;
  assign shr  = {SrcA, 1'b0} >> SrcB;
  assign sar  = $signed({SrcA, 1'b0}) >>> SrcB;
  assign rot  = W'({SrcA, SrcA} >> ramt);
  assign big  = ({1'b0, SrcB} >= WIDTH_V);
  assign zamt = (SrcB == '0);

  always_comb begin
    res   = '0;
    co_n  = CO;
    ovf_n = OVF;
    ax    = '0;
    ay    = '0;
    cin   = 1'b0;
    arith = 1'b0;
    case (Control)
      4'b0000: begin ax = SrcA; ay = SrcB;  cin = 1'b0; arith = 1'b1; end
      4'b0001: begin ax = SrcA; ay = ~SrcB; cin = 1'b1; arith = 1'b1; end
      4'b0010: begin ax = SrcB; ay = ~SrcA; cin = 1'b1; arith = 1'b1; end
      4'b0011: begin ax = SrcA; ay = SrcB;  cin = CO;   arith = 1'b1; end
      4'b0100: begin ax = SrcA; ay = ~SrcB; cin = CO;   arith = 1'b1; end
      4'b0101: res = SrcA & SrcB;
      4'b0110: res = SrcA | SrcB;
      4'b0111: res = SrcA ^ SrcB;
      4'b1000: res = SrcA & ~SrcB;
      4'b1001: res = SrcB;
      4'b1010: res = ~SrcB;
      4'b1100: begin
        if (zamt)     res = SrcA;
        else if (big) begin res = '0; co_n = 1'b0; end
        else          begin res = shl[W-1:0]; co_n = shl[W]; end
      end
      4'b1101: begin
        if (zamt)     res = SrcA;
        else if (big) begin res = '0; co_n = 1'b0; end
        else          begin res = shr[W:1]; co_n = shr[0]; end
      end
      4'b1110: begin
        if (zamt)     res = SrcA;
        else if (big) begin res = {W{SrcA[W-1]}}; co_n = SrcA[W-1]; end
        else          begin res = sar[W:1]; co_n = sar[0]; end
      end
      4'b1111: begin
        res = rot;
        if (ramt != '0) co_n = rot[W-1];
      end
      default: res = '0;
    endcase
    sum = {1'b0, ax} + {1'b0, ay} + {{W{1'b0}}, cin};
    if (arith) begin
      res   = sum[W-1:0];
      co_n  = sum[W];
      ovf_n = (ax[W-1] == ay[W-1]) && (sum[W-1] != ax[W-1]);
    end
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      Result <= '0;
      CO     <= 1'b0;
      OVF    <= 1'b0;
      N      <= 1'b0;
      Z      <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (Control == OP_MUL) begin
          acc    <= '0;
          mcand  <= {{W{1'b0}}, SrcA};
          mplier <= SrcB;
          cnt    <= '0;
        end else begin
          Result <= res;
          CO     <= co_n;
          OVF    <= ovf_n;
          N      <= res[W-1];
          Z      <= (res == '0);
          done   <= 1'b1;
        end
      end else if (state == MULT) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) begin
          Result <= acc_nxt[W-1:0];
          OVF    <= |acc_nxt[2*W-1:W];
          N      <= acc_nxt[W-1];
          Z      <= (acc_nxt[W-1:0] == '0);
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at W=8; flags are compared packed as {CO,OVF,N,Z}.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] SrcA = '0;
  logic [7:0] SrcB = '0;
  logic [3:0] Control = '0;
  logic       busy, done, CO, OVF, N, Z;
  logic [7:0] Result;

  int ncmp = 0;
  int nerr = 0;
  int bad;

  alu_seq #(.W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .SrcA(SrcA), .SrcB(SrcB), .Control(Control),
    .busy(busy), .done(done), .Result(Result),
    .CO(CO), .OVF(OVF), .N(N), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for exactly one rising edge, then samples 1 time unit after it.
  task automatic op(input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    Control = ctl; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("reset_result", Result, 8'h00);
    chk("reset_flags", {CO, OVF, N, Z}, 4'b0000);
    chk("reset_busy_done", {busy, done}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;

    op(4'b0000, 8'h7F, 8'h01);
    chk("add_ovf_result", Result, 8'h80);
    chk("add_ovf_flags", {CO, OVF, N, Z}, 4'b0110);
    chk("add_ovf_done", done, 1'b1);
    step();
    chk("add_ovf_done_drop", done, 1'b0);
    chk("add_ovf_hold", Result, 8'h80);

    op(4'b0001, 8'h05, 8'h05);
    chk("sub_zero_result", Result, 8'h00);
    chk("sub_zero_flags", {CO, OVF, N, Z}, 4'b1001);

    op(4'b0000, 8'hFF, 8'h01);
    chk("add_carry_flags", {CO, OVF, N, Z}, 4'b1001);
    op(4'b0011, 8'h10, 8'h20);
    chk("adc_result", Result, 8'h31);
    chk("adc_flags", {CO, OVF, N, Z}, 4'b0000);
    chk("adc_done", done, 1'b1);
    op(4'b0100, 8'h10, 8'h01);
    chk("sbc_result", Result, 8'h0E);
    chk("sbc_flags", {CO, OVF, N, Z}, 4'b1000);

    op(4'b1011, 8'h0F, 8'h11);
    chk("mul1_busy_accept", {busy, done}, 2'b10);
    bad = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      if (busy !== 1'b1 || done !== 1'b0 || Result !== 8'h0E) bad++;
    end
    chk("mul1_busy_cycles", bad, 0);
    step();
    chk("mul1_done", {busy, done}, 2'b01);
    chk("mul1_result", Result, 8'hFF);
    chk("mul1_flags", {CO, OVF, N, Z}, 4'b1010);
    step();
    chk("mul1_done_drop", done, 1'b0);

    op(4'b1011, 8'h10, 8'h10);
    @(negedge clk);
    Control = 4'b0101; SrcA = 8'hF0; SrcB = 8'h3C; start = 1'b1;
    bad = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      if (busy !== 1'b1 || done !== 1'b0 || Result !== 8'hFF) bad++;
    end
    start = 1'b0;
    chk("mul2_ignore_start", bad, 0);
    step();
    chk("mul2_done", {busy, done}, 2'b01);
    chk("mul2_result", Result, 8'h00);
    chk("mul2_flags", {CO, OVF, N, Z}, 4'b1101);
    step();
    chk("mul2_no_and", {done, Result}, 9'h000);

    op(4'b1011, 8'h03, 8'h05);
    repeat (3) step();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mul_flags", {CO, OVF, N, Z}, 4'b0000);
    chk("rst_mid_mul_ctl", {busy, done, Result}, 10'h000);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rst_no_done", bad, 0);
    op(4'b0000, 8'h01, 8'h02);
    chk("add_after_rst", Result, 8'h03);
    chk("add_after_rst_flags", {CO, OVF, N, Z}, 4'b0000);

    op(4'b0010, 8'h01, 8'h03);
    chk("rsb_result", Result, 8'h02);
    chk("rsb_flags", {CO, OVF, N, Z}, 4'b1000);

    op(4'b1101, 8'h81, 8'h01);
    chk("lsr_result", Result, 8'h40);
    chk("lsr_flags", {CO, OVF, N, Z}, 4'b1000);
    op(4'b1110, 8'h80, 8'h03);
    chk("asr_result", Result, 8'hF0);
    chk("asr_flags", {CO, OVF, N, Z}, 4'b0010);
    op(4'b1100, 8'h81, 8'h09);
    chk("lsl_big_result", Result, 8'h00);
    chk("lsl_big_flags", {CO, OVF, N, Z}, 4'b0001);
    op(4'b1111, 8'h01, 8'h01);
    chk("ror_result", Result, 8'h80);
    chk("ror_flags", {CO, OVF, N, Z}, 4'b1010);
    op(4'b1110, 8'h80, 8'h08);
    chk("asr_big_result", Result, 8'hFF);
    chk("asr_big_flags", {CO, OVF, N, Z}, 4'b1010);

    op(4'b0000, 8'h80, 8'h80);
    chk("add_co_ovf_flags", {CO, OVF, N, Z}, 4'b1101);
    op(4'b1100, 8'h55, 8'h00);
    chk("lsl0_result", Result, 8'h55);
    chk("lsl0_flags", {CO, OVF, N, Z}, 4'b1100);

    op(4'b0000, 8'hFF, 8'h01);
    op(4'b1000, 8'hFF, 8'h0F);
    chk("bic_result", Result, 8'hF0);
    chk("bic_flags", {CO, OVF, N, Z}, 4'b1010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
